// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx -- parses 7-byte host command frames (AA CMD D0 D1 D2 D3 CSUM) from the
// UART receiver and updates the camera colour-threshold registers. Rev 1.0
`default_nettype none

module uart_cmd_rx #(
  parameter logic [7:0]  HEADER    = 8'hAA,
  parameter logic [23:0] TIMEOUT   = 24'd1_000_000,
  parameter logic [31:0] RMAX_INIT = 32'h0000_8000,
  parameter logic [31:0] GMIN_INIT = 32'h0000_4000,
  parameter logic [31:0] BMAX_INIT = 32'h0000_8000,
  parameter logic [31:0] CMIN_INIT = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_done,
  input  logic [7:0]  read_data,
  output logic [31:0] r_max,
  output logic [31:0] g_min,
  output logic [31:0] b_max,
  output logic [31:0] c_min,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3
  } state_t;

  localparam logic [23:0] TMO_LAST = TIMEOUT - 24'd1;

  state_t      cur;
  logic        rd_d;
  logic [1:0]  idx;
  logic [23:0] tmo_cnt;
  logic [31:0] shreg;
  logic [7:0]  cmd;
  logic [7:0]  xsum;

  logic        accept;
  logic        timeout_hit;
  logic        csum_good;
  logic [7:0]  err_next;

  assign accept      = read_done & ~rd_d;
  // An accept in the expiry cycle keeps the frame alive.
  assign timeout_hit = (cur != S_IDLE) && !accept && (tmo_cnt == TMO_LAST);
  assign csum_good   = (read_data == xsum) && (cmd <= 8'd3);
  assign err_next    = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  assign state       = cur;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur       <= S_IDLE;
      rd_d      <= 1'b0;
      idx       <= 2'd0;
      tmo_cnt   <= 24'd0;
      shreg     <= 32'd0;
      cmd       <= 8'd0;
      xsum      <= 8'd0;
      r_max     <= RMAX_INIT;
      g_min     <= GMIN_INIT;
      b_max     <= BMAX_INIT;
      c_min     <= CMIN_INIT;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      rd_d      <= read_done;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;

      if (cur == S_IDLE || accept) begin
        tmo_cnt <= 24'd0;
      end else begin
        tmo_cnt <= tmo_cnt + 24'd1;
      end

      if (timeout_hit) begin
        cur       <= S_IDLE;
        frame_err <= 1'b1;
        err_cnt   <= err_next;
        tmo_cnt   <= 24'd0;
      end else if (accept) begin
        case (cur)
          S_IDLE: begin
            if (read_data == HEADER) begin
              cur <= S_CMD;
            end
          end
          S_CMD: begin
            cmd   <= read_data;
            xsum  <= read_data;
            shreg <= 32'd0;
            idx   <= 2'd0;
            cur   <= S_DATA;
          end
          S_DATA: begin
            shreg[{idx, 3'b000} +: 8] <= read_data;
            xsum <= xsum ^ read_data;
            idx  <= idx + 2'd1;
            if (idx == 2'd3) begin
              cur <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (csum_good) begin
              case (cmd[1:0])
                2'd0:    r_max <= shreg;
                2'd1:    g_min <= shreg;
                2'd2:    b_max <= shreg;
                default: c_min <= shreg;
              endcase
              frame_ok <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              err_cnt   <= err_next;
            end
            cur <= S_IDLE;
          end
          default: cur <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx -- randomized scoreboard bench for uart_cmd_rx against a frame-level model.
`default_nettype none

module tb_uart_cmd_rx;

  localparam logic [31:0] RMAX_I = 32'h0000_8000;
  localparam logic [31:0] GMIN_I = 32'h0000_4000;
  localparam logic [31:0] BMAX_I = 32'h0000_8000;
  localparam logic [31:0] CMIN_I = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        read_done = 1'b0;
  logic [7:0]  read_data = 8'h00;
  logic [31:0] r_max, g_min, b_max, c_min;
  logic        frame_ok, frame_err;
  logic [7:0]  err_cnt;
  logic [2:0]  state;

  uart_cmd_rx #(.TIMEOUT(24'd100)) dut (
    .clk(clk), .rst(rst), .read_done(read_done), .read_data(read_data),
    .r_max(r_max), .g_min(g_min), .b_max(b_max), .c_min(c_min),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ok;
    logic [31:0] r, g, b, c;
    logic [7:0]  ec;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  frm[$];
  logic [31:0] m_regs[4];
  logic [7:0]  m_err;
  int          checks = 0;
  int          fails  = 0;

  task automatic model_reset();
    m_regs[0] = RMAX_I; m_regs[1] = GMIN_I; m_regs[2] = BMAX_I; m_regs[3] = CMIN_I;
    m_err = 8'd0;
    frm.delete();
    exp_q.delete();
  endtask

  task automatic push_exp(input logic ok);
    exp_t e;
    e.ok = ok; e.r = m_regs[0]; e.g = m_regs[1]; e.b = m_regs[2]; e.c = m_regs[3]; e.ec = m_err;
    exp_q.push_back(e);
  endtask

  task automatic model_err();
    if (m_err != 8'hFF) m_err = m_err + 8'd1;
    push_exp(1'b0);
    frm.delete();
  endtask

  // Frame-level rule: collect 7 bytes starting at a header, then judge the whole frame.
  task automatic model_byte(input logic [7:0] b, output bit done);
    logic [7:0] cs;
    done = 0;
    if (frm.size() == 0 && b != 8'hAA) return;
    frm.push_back(b);
    if (frm.size() < 7) return;
    cs = frm[1] ^ frm[2] ^ frm[3] ^ frm[4] ^ frm[5];
    done = 1;
    if (frm[6] == cs && frm[1] < 8'd4) begin
      m_regs[frm[1][1:0]] = {frm[5], frm[4], frm[3], frm[2]};
      push_exp(1'b1);
      frm.delete();
    end else begin
      model_err();
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_model(input string name);
    check({name, " r_max"}, r_max, m_regs[0]);
    check({name, " g_min"}, g_min, m_regs[1]);
    check({name, " b_max"}, b_max, m_regs[2]);
    check({name, " c_min"}, c_min, m_regs[3]);
    check({name, " err_cnt"}, {24'd0, err_cnt}, {24'd0, m_err});
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold);
    bit done;
    @(posedge clk); #1;
    read_data = b;
    read_done = 1'b1;
    model_byte(b, done);
    @(posedge clk);
    @(negedge clk);
    if (done) check("pulse latency", {31'd0, frame_ok | frame_err}, 32'd1);
    if (hold > 1) begin
      repeat (hold - 1) @(posedge clk);
      #1;
    end
    read_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] val, input bit bad, input int hold);
    logic [7:0] cs;
    cs = cmd ^ val[7:0] ^ val[15:8] ^ val[23:16] ^ val[31:24];
    if (bad) cs = cs ^ 8'h5A;
    send_byte(8'hAA, hold);
    send_byte(cmd, hold);
    for (int i = 0; i < 4; i++) send_byte(val[8*i +: 8], hold);
    send_byte(cs, hold);
  endtask

  // Scoreboard monitor: every pulse must match the next expected frame outcome.
  always @(negedge clk) begin
    if (rst && (frame_ok || frame_err)) begin
      exp_t e;
      checks++;
      if (frame_ok && frame_err) begin
        fails++;
        $display("FAIL monitor: frame_ok and frame_err both high");
      end else if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL monitor: unexpected pulse ok=%b err=%b", frame_ok, frame_err);
      end else begin
        e = exp_q.pop_front();
        if (e.ok !== frame_ok || e.r !== r_max || e.g !== g_min || e.b !== b_max ||
            e.c !== c_min || e.ec !== err_cnt) begin
          fails++;
          $display("FAIL monitor: got ok=%b r=%h g=%h b=%h c=%h ec=%h expected ok=%b r=%h g=%h b=%h c=%h ec=%h",
                   frame_ok, r_max, g_min, b_max, c_min, err_cnt, e.ok, e.r, e.g, e.b, e.c, e.ec);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit done;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset state", {29'd0, state}, 32'd0);
    check_model("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(8'h00, 32'h0000_1234, 0, 1);
    check("r_max 1234", r_max, 32'h0000_1234);
    check("g_min held", g_min, GMIN_I);
    @(negedge clk);
    check("frame_ok width", {31'd0, frame_ok}, 32'd0);

    send_frame(8'h03, 32'h0000_00FF, 0, 2);
    check("c_min FF", c_min, 32'h0000_00FF);
    send_byte(8'hAA, 1); send_byte(8'h02, 1); send_byte(8'h01, 1);
    send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
    check("bad csum err_cnt", {24'd0, err_cnt}, 32'd1);
    check("bad csum b_max", b_max, BMAX_I);

    send_frame(8'h05, 32'h0, 0, 1);
    check("invalid cmd err_cnt", {24'd0, err_cnt}, 32'd2);
    check_model("after invalid cmd");

    for (int k = 0; k < 60; k++) begin
      logic [7:0] c;
      if ($urandom_range(0, 4) == 0) begin
        c = 8'($urandom);
        if (c == 8'hAA) c = 8'h55;
        send_byte(c, int'($urandom_range(1, 3)));
      end
      c = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
      send_frame(c, $urandom, $urandom_range(0, 4) == 0, int'($urandom_range(1, 3)));
    end
    check_model("random");

    // Timeout: header, cmd, one data byte, then silence.
    send_byte(8'hAA, 1);
    send_byte(8'h01, 1);
    @(posedge clk); #1;
    read_data = 8'h10;
    read_done = 1'b1;
    model_byte(8'h10, done);
    model_err();
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 2) read_done = 1'b0;
      if (frame_err) break;
    end
    check("timeout cycles", n, 32'd100);
    check("timeout state", {29'd0, state}, 32'd0);
    send_frame(8'h01, 32'h0000_0010, 0, 1);
    check("g_min 10", g_min, 32'h0000_0010);

    send_byte(8'hAA, 50);
    send_byte(8'h02, 1);
    for (int i = 0; i < 4; i++) send_byte(8'h11 * (i + 1), 1);
    send_byte(8'h02 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44, 1);
    check("held read_done", b_max, 32'h4433_2211);

    send_byte(8'h55, 1);
    send_byte(8'h13, 1);
    repeat (3) @(negedge clk);
    check("garbage ignored", {24'd0, err_cnt}, {24'd0, m_err});
    check("garbage state", {29'd0, state}, 32'd0);

    send_byte(8'hAA, 1); send_byte(8'h00, 1); send_byte(8'h01, 1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    model_reset();
    check("mid-frame reset r_max", r_max, RMAX_I);
    check("mid-frame reset state", {29'd0, state}, 32'd0);
    check_model("mid-frame reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < 300; k++) send_frame(8'h05, 32'h0, 1, 1);
    check("err_cnt saturate", {24'd0, err_cnt}, 32'hFF);
    check_model("final");

    repeat (5) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
